// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state and phase constants for the phase sequencer
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } seq_state_t;

    localparam logic [2:0] PHASE_FIRST = 3'd0;
    localparam logic [2:0] PHASE_LAST  = 3'd7;
    localparam logic [2:0] PHASE_HALT  = 3'd4;

    function automatic logic is_active(input seq_state_t s);
        return (s == S_RUN) || (s == S_STEP);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - 8-phase fetch/execute sequencer with stall watchdog and debug counters
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             clr_halt,
    input  logic             clr_cnt,
    input  logic             halt,
    input  logic             mem_req,
    input  logic             mem_rdy,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             instr_done,
    output logic             bus_err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int SW = $clog2(STALL_MAX + 1);

    seq_state_t    state;
    logic          stop_pend;
    logic [SW-1:0] stall_cnt;
    logic          active;
    logic          stalled;
    logic          wd_fire;
    logic          complete;

    assign active   = is_active(state);
    assign stalled  = mem_req && !mem_rdy;
    assign wd_fire  = active && stalled && (stall_cnt == SW'(STALL_MAX - 1));
    // The HLT instruction retires like a normal wrap; a watchdog abort does not.
    assign complete = active && !stalled && (halt || (phase == PHASE_LAST));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= S_IDLE;
            phase      <= PHASE_FIRST;
            running    <= 1'b0;
            halted     <= 1'b0;
            instr_done <= 1'b0;
            bus_err    <= 1'b0;
            stop_pend  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            instr_done <= complete;
            case (state)
                S_IDLE: begin
                    phase     <= PHASE_FIRST;
                    stop_pend <= 1'b0;
                    stall_cnt <= '0;
                    if (start) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end else if (step) begin
                        state   <= S_STEP;
                        running <= 1'b1;
                    end
                end
                S_HALTED: begin
                    phase     <= PHASE_FIRST;
                    stop_pend <= 1'b0;
                    stall_cnt <= '0;
                    if (clr_halt) begin
                        state   <= S_IDLE;
                        halted  <= 1'b0;
                        bus_err <= 1'b0;
                    end
                end
                default: begin
                    stop_pend <= (state == S_RUN) && (stop_pend || stop);
                    if (stalled) begin
                        if (wd_fire) begin
                            state     <= S_HALTED;
                            running   <= 1'b0;
                            halted    <= 1'b1;
                            bus_err   <= 1'b1;
                            phase     <= PHASE_FIRST;
                            stall_cnt <= '0;
                            stop_pend <= 1'b0;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        stall_cnt <= '0;
                        if (halt) begin
                            state     <= S_HALTED;
                            running   <= 1'b0;
                            halted    <= 1'b1;
                            phase     <= PHASE_FIRST;
                            stop_pend <= 1'b0;
                        end else if (phase == PHASE_LAST) begin
                            phase <= PHASE_FIRST;
                            if ((state == S_STEP) || stop_pend || stop) begin
                                state     <= S_IDLE;
                                running   <= 1'b0;
                                stop_pend <= 1'b0;
                            end
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk  (clk),
        .rst_ (rst_),
        .clr  (clr_cnt),
        .en   (active),
        .q    (cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk  (clk),
        .rst_ (rst_),
        .clr  (clr_cnt),
        .en   (complete),
        .q    (instr_cnt)
    );

endmodule
